nes_button_events: RTL and testbench
====================================

# nes_button_events

Downstream consumer of the NES controller reader. It takes each 8-bit button snapshot the reader produces once per poll, debounces it across consecutive polls, and maintains a stable pressed-button vector. It detects per-button press/release edges and serialises them into a small event FIFO with a valid/ready output. Game or UI logic reads discrete button events from this FIFO instead of raw LEDs/levels.

## Interface
- POLL_STABLE, 2: consecutive identical polls required to commit a new button vector; legal range 1..15.
- FIFO_DEPTH, 8: event FIFO depth; power of 2, 2..64.
- ACTIVE_LOW, 1: 1 means the input bit 0 = pressed (native NES shift data); 0 means the input bit 1 = pressed.

- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- buttons_in  in  8  raw snapshot from reader; bit order 0=A, 1=B, 2=SELECT, 3=START, 4=UP, 5=DOWN, 6=LEFT, 7=RIGHT.
- buttons_valid  in  1  one-cycle strobe; buttons_in is valid on this cycle.
- buttons_stable  out  8  debounced vector, 1 = pressed (always active-high).
- evt_valid  out  1  FIFO non-empty.
- evt_data  out  4  head event; [3] = 1 press, 0 release; [2:0] = button index.
- evt_ready  in  1  consumer pops the head when evt_valid && evt_ready.
- fifo_count  out  clog2(FIFO_DEPTH)+1  number of queued events.
- overflow  out  1  sticky; set when an event is dropped.
- clr_overflow  in  1  synchronous clear of overflow.
- busy  out  1  high while SCAN is in progress.

## Operation
- Normalise: s = ACTIVE_LOW ? ~buttons_in : buttons_in.
- Debounce, updated only on buttons_valid:
  - If s == last_sample, stable_cnt saturates-increments (max POLL_STABLE-1).
  - Otherwise, last_sample <= s and stable_cnt <= 0.
- Commit condition, evaluated on a buttons_valid cycle:
  - The cycle's post-update stable_cnt == POLL_STABLE-1.
  - s != buttons_stable.
  - state == IDLE.
  - With POLL_STABLE=1, every differing poll commits.
- On commit: diff <= s ^ buttons_stable; buttons_stable <= s; newstate <= s; state -> SCAN with idx = 0.
- A commit condition met while in SCAN is not taken. stable_cnt stays saturated, so the commit happens on the next qualifying buttons_valid in IDLE.
- SCAN: one index per cycle, idx 0..7.
  - If diff[idx] is set, push {newstate[idx], idx}.
  - After idx = 7, return to IDLE. SCAN lasts exactly 8 cycles.
- FIFO: first-word-fall-through; evt_data = mem[rd_ptr]; pointers wrap modulo FIFO_DEPTH.
- Push accepted if fifo_count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the event is dropped and overflow <= 1.
- Simultaneous push and pop: fifo_count is unchanged.
- Pop when empty is ignored.
- overflow: a set caused by a drop wins over clr_overflow in the same cycle.
- busy = (state == SCAN).

## Timing
- Reset values:
  - buttons_stable = 0, last_sample = 0, stable_cnt = 0.
  - state IDLE, busy = 0.
  - FIFO empty: fifo_count = 0, evt_valid = 0, evt_data = mem[0] (don't-care).
  - overflow = 0.
- Commit latency:
  - For a buttons_valid sampled at edge T, buttons_stable updates at T and busy rises after T.
  - Bit idx is pushed at edge T+1+idx.
  - evt_valid rises after that edge if the FIFO was empty.
  - busy falls after edge T+8.
- Pop: at the edge where evt_valid && evt_ready, the next entry (or evt_valid = 0) is visible after that edge.
- Reset asserted mid-SCAN or mid-debounce aborts immediately. The FIFO is flushed and all outputs take their reset values.

## Test plan
- Press/release A:
  - Stimulus: reset, then 2 polls of 0xFE.
  - Response: buttons_stable = 0x01 after the 2nd poll; one event 0x8; busy high 8 cycles.
  - Then 2 polls of 0xFF -> one event 0x0; buttons_stable = 0x00.
- Glitch rejection: polls 0xFF, 0xFD, 0xFF, 0xFF -> no event; buttons_stable stays 0x00.
- Multi-press:
  - Stimulus: 2 polls of 0x00, evt_ready held 1.
  - Response: events 0x8, 0x9, ..., 0xF in index order, one per cycle starting at edge T+1.
- Overflow:
  - Stimulus: FIFO_DEPTH = 8, evt_ready = 0; all pressed, then all released.
  - Response: fifo_count = 8, entries 0x8..0xF kept, releases dropped, overflow = 1.
  - Pulse clr_overflow -> overflow = 0.
- Full with simultaneous pop: FIFO full, evt_ready = 1 during a push -> push accepted, fifo_count stays 8, overflow stays 0.
- Reset mid-SCAN: assert reset at idx 3 -> fifo_count = 0, evt_valid = 0, buttons_stable = 0, busy = 0 immediately.

Source files
------------

// File: rtl/nes_button_events.sv
// nes_button_events
//   Turns per-poll NES button snapshots into a debounced pressed vector and a
//   queue of discrete press/release events.
//
//   Ports:
//     clk, reset        clock; asynchronous active-high reset
//     buttons_in[7:0]   raw snapshot (0=A 1=B 2=SELECT 3=START 4=UP 5=DOWN 6=LEFT 7=RIGHT)
//     buttons_valid     one-cycle strobe qualifying buttons_in
//     buttons_stable    debounced vector, 1 = pressed
//     evt_valid/ready   FIFO head handshake; evt_data = {press, index}
//     fifo_count        queued event count
//     overflow          sticky drop flag, cleared by clr_overflow
//     busy              high while the changed-bit scan runs (8 cycles)
module nes_button_events #(
  parameter int POLL_STABLE = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   buttons_in,
  input  logic                         buttons_valid,
  output logic [7:0]                   buttons_stable,
  output logic                         evt_valid,
  output logic [3:0]                   evt_data,
  input  logic                         evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow,
  input  logic                         clr_overflow,
  output logic                         busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] CNT_MAX = 4'(POLL_STABLE - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  typedef struct packed {
    logic       press;
    logic [2:0] idx;
  } evt_t;

  state_t     state;
  logic [7:0] s, last_sample, diff, newstate;
  logic [3:0] stable_cnt, cnt_next;
  logic [2:0] idx;
  logic       commit;

  // Debounce: count consecutive identical polls, saturating at CNT_MAX.
  assign s        = ACTIVE_LOW ? ~buttons_in : buttons_in;
  assign cnt_next = (s != last_sample)    ? 4'd0 :
                    (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + 4'd1;
  // A qualifying poll seen during SCAN is skipped; the saturated counter
  // lets the next qualifying poll in IDLE take it.
  assign commit   = buttons_valid && (cnt_next == CNT_MAX) &&
                    (s != buttons_stable) && (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_sample    <= '0;
      stable_cnt     <= '0;
      buttons_stable <= '0;
      diff           <= '0;
      newstate       <= '0;
      idx            <= '0;
      state          <= IDLE;
      busy           <= 1'b0;
    end else begin
      if (buttons_valid) begin
        last_sample <= s;
        stable_cnt  <= cnt_next;
      end
      case (state)
        IDLE: if (commit) begin
          diff           <= s ^ buttons_stable;
          buttons_stable <= s;
          newstate       <= s;
          idx            <= '0;
          state          <= SCAN;
          busy           <= 1'b1;
        end
        SCAN: begin
          idx <= idx + 3'd1;
          if (idx == 3'd7) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Event FIFO, first-word-fall-through.
  evt_t            mem [FIFO_DEPTH];
  evt_t            push_data;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic            push, pop, push_ok;

  assign push      = (state == SCAN) && diff[idx];
  assign push_data = '{press: newstate[idx], idx: idx};
  assign evt_valid = (fifo_count != '0);
  assign evt_data  = mem[rd_ptr];
  assign pop       = evt_valid && evt_ready;
  // When full, a same-cycle pop frees the slot being written.
  assign push_ok   = push && ((fifo_count < CW'(FIFO_DEPTH)) || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      // A drop in the same cycle outranks the clear.
      if (push && !push_ok) overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nes_button_events.sv
module tb_nes_button_events;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] buttons_in = 8'hFF;
  logic       buttons_valid = 1'b0;
  logic [7:0] buttons_stable;
  logic       evt_valid;
  logic [3:0] evt_data;
  logic       evt_ready = 1'b0;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       clr_overflow = 1'b0;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;
  logic [3:0] exp_q [$];

  nes_button_events #(.POLL_STABLE(2), .FIFO_DEPTH(8), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .buttons_in(buttons_in), .buttons_valid(buttons_valid),
    .buttons_stable(buttons_stable), .evt_valid(evt_valid), .evt_data(evt_data),
    .evt_ready(evt_ready), .fifo_count(fifo_count), .overflow(overflow),
    .clr_overflow(clr_overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every pop the DUT will perform at the next edge is matched
  // against the oldest expected event.
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL evt_unexpected: observed 0x%0h expected none", evt_data);
      end
      if (exp_q.size() != 0) check("evt_data", evt_data, exp_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One poll: strobe lands on the next edge; returns 1 time unit after it.
  task automatic poll(input logic [7:0] b);
    buttons_in    = b;
    buttons_valid = 1'b1;
    tick(1);
    buttons_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(2);
    reset = 1'b0;
    check("rst_stable", buttons_stable, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_count", fifo_count, 4'd0);
    check("rst_valid", evt_valid, 1'b0);
    check("rst_ovf", overflow, 1'b0);

    // Press / release A
    evt_ready = 1'b1;
    exp_q.push_back(4'h8);
    poll(8'hFE);
    check("a_first_poll_stable", buttons_stable, 8'h00);
    poll(8'hFE);
    check("a_press_stable", buttons_stable, 8'h01);
    check("a_busy_rise", busy, 1'b1);
    tick(1);
    check("a_evt_valid_t1", evt_valid, 1'b1);
    check("a_evt_data_t1", evt_data, 4'h8);
    tick(6);
    check("a_busy_t7", busy, 1'b1);
    tick(1);
    check("a_busy_t8", busy, 1'b0);
    exp_q.push_back(4'h0);
    poll(8'hFF);
    poll(8'hFF);
    check("a_release_stable", buttons_stable, 8'h00);
    tick(10);
    check("a_drained_count", fifo_count, 4'd0);
    check("a_queue_empty", exp_q.size(), 0);

    // Glitch rejection
    poll(8'hFF); poll(8'hFD); poll(8'hFF); poll(8'hFF);
    tick(10);
    check("glitch_stable", buttons_stable, 8'h00);
    check("glitch_count", fifo_count, 4'd0);
    check("glitch_busy", busy, 1'b0);

    // Multi-press, consumed as produced
    for (int i = 0; i < 8; i++) exp_q.push_back(4'(8 + i));
    poll(8'h00);
    poll(8'h00);
    check("multi_stable", buttons_stable, 8'hFF);
    tick(1);
    check("multi_valid_t1", evt_valid, 1'b1);
    check("multi_data_t1", evt_data, 4'h8);
    tick(8);
    check("multi_count", fifo_count, 4'd0);
    check("multi_queue_empty", exp_q.size(), 0);

    // Release all (drained), then overflow with the consumer stalled
    for (int i = 0; i < 8; i++) exp_q.push_back(4'(i));
    poll(8'hFF); poll(8'hFF);
    tick(10);
    check("rel_queue_empty", exp_q.size(), 0);
    evt_ready = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(4'(8 + i));
    poll(8'h00); poll(8'h00);
    tick(9);
    check("full_count", fifo_count, 4'd8);
    check("full_ovf_clear", overflow, 1'b0);
    poll(8'hFF); poll(8'hFF);   // releases are dropped
    tick(9);
    check("ovf_count", fifo_count, 4'd8);
    check("ovf_set", overflow, 1'b1);
    check("ovf_head", evt_data, 4'h8);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    check("ovf_cleared", overflow, 1'b0);

    // Full FIFO with a pop in the same cycle as the push
    exp_q.push_back(4'h8);
    poll(8'hFE); poll(8'hFE);   // commit; A press pushed at next edge
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    check("fullpop_count", fifo_count, 4'd8);
    check("fullpop_ovf", overflow, 1'b0);
    evt_ready = 1'b1;
    tick(12);
    check("fullpop_drained", fifo_count, 4'd0);
    check("fullpop_queue_empty", exp_q.size(), 0);
    check("fullpop_ovf_end", overflow, 1'b0);

    // Reset in the middle of a scan
    evt_ready = 1'b0;
    poll(8'h00); poll(8'h00);   // press B..RIGHT
    tick(3);                    // scanning idx 3
    check("midscan_busy", busy, 1'b1);
    check("midscan_count", fifo_count, 4'd2);
    reset = 1'b1;
    #1;
    check("rstscan_count", fifo_count, 4'd0);
    check("rstscan_valid", evt_valid, 1'b0);
    check("rstscan_stable", buttons_stable, 8'h00);
    check("rstscan_busy", busy, 1'b0);
    exp_q.delete();
    tick(2);
    reset = 1'b0;

    // Normal operation resumes after reset
    evt_ready = 1'b1;
    exp_q.push_back(4'h9);
    poll(8'hFD); poll(8'hFD);
    check("post_rst_stable", buttons_stable, 8'h02);
    tick(10);
    check("post_rst_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
